// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: opcode encoding and requester state encoding.
package tinyalu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 16;

  typedef enum logic [OP_W-1:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100
  } operation_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } req_state_t;

endpackage

// File: rtl/tinyalu_requester.sv
// Command-side initiator for TinyALU: issues one op at a time, waits for done
// (with timeout), drains residual done pulses, and holds the response slot.
module tinyalu_requester
  import tinyalu_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_err
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DCNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(TIMEOUT - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  req_state_t         state, state_d;
  logic [WCNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic [DCNT_W-1:0]  drain_cnt, drain_cnt_d;
  logic [DATA_W-1:0]  alu_a_d, alu_b_d;
  logic [OP_W-1:0]    alu_op_d, rsp_op_d;
  logic               alu_start_d, rsp_valid_d, rsp_err_d;
  logic [RES_W-1:0]   rsp_result_d;

  // Single outstanding op: only accept from IDLE with an empty response slot.
  assign cmd_ready = (state == IDLE) && !rsp_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      drain_cnt  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_d;
      wait_cnt   <= wait_cnt_d;
      drain_cnt  <= drain_cnt_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_op     <= alu_op_d;
      alu_start  <= alu_start_d;
      rsp_valid  <= rsp_valid_d;
      rsp_result <= rsp_result_d;
      rsp_op     <= rsp_op_d;
      rsp_err    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    wait_cnt_d   = wait_cnt;
    drain_cnt_d  = drain_cnt;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_op_d     = alu_op;
    alu_start_d  = alu_start;
    rsp_valid_d  = rsp_valid;
    rsp_result_d = rsp_result;
    rsp_op_d     = rsp_op;
    rsp_err_d    = rsp_err;

    if (rsp_valid && rsp_ready) rsp_valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op == no_op) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_op_d     = cmd_op;
            rsp_err_d    = 1'b0;
          end else begin
            alu_a_d     = cmd_a;
            alu_b_d     = cmd_b;
            alu_op_d    = cmd_op;
            alu_start_d = 1'b1;
            wait_cnt_d  = '0;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (alu_done) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_op_d     = alu_op;
          rsp_err_d    = 1'b0;
          alu_start_d  = 1'b0;
          drain_cnt_d  = '0;
          state_d      = DRAIN;
        end else if (wait_cnt == WAIT_LAST) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_op_d     = alu_op;
          rsp_err_d    = 1'b1;
          alu_start_d  = 1'b0;
          drain_cnt_d  = '0;
          state_d      = DRAIN;
        end else begin
          wait_cnt_d = wait_cnt + WCNT_W'(1);
        end
      end
      // Operands stay put while residual done pulses die out.
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_d = IDLE;
        else drain_cnt_d = drain_cnt + DCNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tinyalu_requester.sv
// Directed bench for tinyalu_requester with a behavioural TinyALU model.
module tb_tinyalu_requester;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_count = 0;
  int start_rises = 0;
  logic start_q = 1'b0;
  logic done_en;

  always #5 clk = ~clk;

  tinyalu_requester dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err)
  );

  // ALU model: single-cycle done repeats while start is high; MUL done is a
  // 4-stage pipeline of start, so it keeps pulsing after start falls.
  logic done_s, d1, d2, d3, done_m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_s <= 1'b0; d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0; done_m <= 1'b0;
    end else begin
      done_s <= alu_start && !alu_op[2] && (alu_op != 3'b000);
      d1     <= alu_start && alu_op[2];
      d2     <= d1;
      d3     <= d2;
      done_m <= d3;
    end
  end
  assign alu_done = done_en && (done_s || done_m);

  always_comb begin
    alu_result = 16'h0000;
    if (alu_op[2]) alu_result = 16'(alu_a) * 16'(alu_b);
    else if (alu_op == 3'b001) alu_result = 16'(alu_a) + 16'(alu_b);
    else if (alu_op == 3'b010) alu_result = {8'h00, alu_a & alu_b};
    else if (alu_op == 3'b011) alu_result = {8'h00, alu_a ^ alu_b};
  end

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) rsp_count = rsp_count + 1;
    if (alu_start && !start_q) start_rises = start_rises + 1;
    start_q = alu_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a command and return (at E0+1) once it has been accepted.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int acc);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout: cmd_ready never rose for op %0d", op);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  // k = index of the first edge after which rsp_valid is seen (E0 = 0).
  task automatic wait_rsp(output int k, output logic [15:0] res, output logic err,
                          output logic [2:0] op);
    k = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        k = n;
        break;
      end
    end
    res = rsp_result; err = rsp_err; op = rsp_op;
    if (k < 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL rsp_timeout: rsp_valid never rose");
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k, acc0, acc1, cnt0, sr0;
    logic [15:0] res;
    logic err;
    logic [2:0] op;

    vecs[0] = '{3'b001, 8'hFF, 8'h01, 16'h0100, 2};
    vecs[1] = '{3'b010, 8'hF0, 8'h3C, 16'h0030, 2};
    vecs[2] = '{3'b011, 8'hA5, 8'h0F, 16'h00AA, 2};
    vecs[3] = '{3'b100, 8'hFF, 8'hFF, 16'hFE01, 5};
    vecs[4] = '{3'b100, 8'h03, 8'h04, 16'h000C, 5};
    vecs[5] = '{3'b000, 8'h05, 8'h07, 16'h0000, 0};
    vecs[6] = '{3'b101, 8'h02, 8'h03, 16'h0006, 5};
    vecs[7] = '{3'b111, 8'h0A, 8'h0A, 16'h0064, 5};
    vecs[8] = '{3'b001, 8'h7F, 8'h80, 16'h00FF, 2};
    vecs[9] = '{3'b110, 8'h10, 8'h10, 16'h0100, 5};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b1; done_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_alu_start", 32'(alu_start), 32'd0);
    check("reset_alu_a", 32'(alu_a), 32'd0);
    check("reset_alu_op", 32'(alu_op), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Table of single operations with rsp_ready held high.
    cnt0 = rsp_count;
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, acc0);
      wait_rsp(k, res, err, op);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
      check($sformatf("vec%0d_latency", i), 32'(k), 32'(vecs[i].lat));
      check($sformatf("vec%0d_op", i), 32'(op), 32'(vecs[i].op));
    end
    repeat (12) @(negedge clk);
    check("table_rsp_count", 32'(rsp_count - cnt0), 32'd10);

    // Back-to-back accept spacing.
    issue(3'b001, 8'h01, 8'h02, acc0);
    wait_rsp(k, res, err, op);
    issue(3'b001, 8'h03, 8'h04, acc1);
    check("add_add_spacing", 32'(acc1 - acc0), 32'd8);
    wait_rsp(k, res, err, op);
    check("add2_result", 32'(res), 32'h0007);
    issue(3'b100, 8'hFF, 8'hFF, acc0);
    wait_rsp(k, res, err, op);
    issue(3'b100, 8'h03, 8'h04, acc1);
    check("mul_mul_spacing", 32'(acc1 - acc0), 32'd11);
    wait_rsp(k, res, err, op);
    check("mul2_result", 32'(res), 32'h000C);
    repeat (12) @(negedge clk);

    // NOP: no ALU activity, back-to-back spacing of 2.
    sr0 = start_rises;
    issue(3'b000, 8'h05, 8'h07, acc0);
    wait_rsp(k, res, err, op);
    check("nop_latency", 32'(k), 32'd0);
    issue(3'b000, 8'h05, 8'h07, acc1);
    check("nop_nop_spacing", 32'(acc1 - acc0), 32'd2);
    wait_rsp(k, res, err, op);
    check("nop_result", 32'(res), 32'd0);
    repeat (3) @(negedge clk);
    check("nop_no_start", 32'(start_rises - sr0), 32'd0);

    // Response held off for 10 cycles.
    rsp_ready = 1'b0;
    issue(3'b011, 8'hA5, 8'h0F, acc0);
    wait_rsp(k, res, err, op);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_result", 32'(rsp_result), 32'h00AA);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_taken", 32'(rsp_valid), 32'd0);
    repeat (4) @(negedge clk);

    // Handshake on the same edge that DRAIN ends.
    rsp_ready = 1'b0;
    issue(3'b001, 8'h01, 8'h01, acc0);
    wait_rsp(k, res, err, op);
    repeat (4) @(negedge clk);
    check("drain_end_ready_low", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    issue(3'b000, 8'h00, 8'h00, acc1);
    check("drain_end_spacing", 32'(acc1 - acc0), 32'd8);
    wait_rsp(k, res, err, op);

    // Timeout with done suppressed, then normal recovery.
    done_en = 1'b0;
    issue(3'b001, 8'h01, 8'h02, acc0);
    wait_rsp(k, res, err, op);
    done_en = 1'b1;
    check("timeout_latency", 32'(k), 32'd15);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_result", 32'(res), 32'd0);
    issue(3'b001, 8'h01, 8'h02, acc0);
    wait_rsp(k, res, err, op);
    check("post_timeout_result", 32'(res), 32'h0003);
    check("post_timeout_err", 32'(err), 32'd0);

    // Reset in the middle of a MUL wait.
    issue(3'b100, 8'h09, 8'h09, acc0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_alu_start", 32'(alu_start), 32'd0);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt0 = rsp_count;
    issue(3'b010, 8'hF0, 8'h3C, acc0);
    wait_rsp(k, res, err, op);
    check("post_reset_result", 32'(res), 32'h0030);
    check("post_reset_latency", 32'(k), 32'd2);
    repeat (10) @(negedge clk);
    check("post_reset_rsp_count", 32'(rsp_count - cnt0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
